// File: rtl/layer7_macro_scheduler.sv
// rtl/layer7_macro_scheduler.sv - Layer-7 CIM macro pass/window sequencer
// Replays the shared macros over PASS_NUM weight banks per input window and qualifies decoder output.
module layer7_macro_scheduler #(
  parameter int PASS_NUM  = 4,
  parameter int MACRO_LAT = 2,
  parameter int WIN_NUM   = 49,
  parameter int SEL_W     = (PASS_NUM > 1) ? $clog2(PASS_NUM) : 1,
  parameter int WIN_W     = (WIN_NUM > 1) ? $clog2(WIN_NUM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             macro_en,
  output logic [SEL_W-1:0] macro_sel,
  input  logic             psum_ready,
  output logic             data_e,
  output logic             psum_clr,
  output logic             psum_last,
  output logic [WIN_W-1:0] win_idx,
  output logic             busy,
  output logic             done
);

  localparam int LAT_W   = (MACRO_LAT > 2) ? $clog2(MACRO_LAT - 1) : 1;
  localparam int LAT_INI = (MACRO_LAT >= 2) ? MACRO_LAT - 2 : 0;

  localparam logic [SEL_W-1:0] PASS_LAST = SEL_W'(PASS_NUM - 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_NUM - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(LAT_INI);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_IN  = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_LAT = 3'd3,
    S_CAPTURE  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] pass_q, pass_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [LAT_W-1:0] lat_q, lat_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
      win_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      win_q   <= win_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    win_d   = win_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_IN;
          pass_d  = '0;
          win_d   = '0;
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // WAIT_LAT spends LAT_INI+1 cycles, so CAPTURE lands MACRO_LAT cycles after macro_en
        if (MACRO_LAT == 1) begin
          state_d = S_CAPTURE;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = S_WAIT_LAT;
        end
      end
      S_WAIT_LAT: begin
        if (lat_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_CAPTURE: begin
        if (psum_ready) begin
          if (pass_q != PASS_LAST) begin
            pass_d  = pass_q + SEL_W'(1);
            state_d = S_ISSUE;
          end else if (win_q != WIN_LAST) begin
            pass_d  = '0;
            win_d   = win_q + WIN_W'(1);
            state_d = S_WAIT_IN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        pass_d  = '0;
        win_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  logic capture;
  assign capture = (state_q == S_CAPTURE);

  // Only data_e looks at an input; everything else is a pure decode of registered state.
  assign in_ready  = (state_q == S_WAIT_IN);
  assign macro_en  = (state_q == S_ISSUE);
  assign macro_sel = (state_q == S_ISSUE || state_q == S_WAIT_LAT || capture) ? pass_q : '0;
  assign data_e    = capture & psum_ready;
  assign psum_clr  = capture && (pass_q == '0);
  assign psum_last = capture && (pass_q == PASS_LAST);
  assign win_idx   = win_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule
